// File: rtl/conv_axis_out_packer.sv
// Byte-to-word packer for the conv_module result path.
// Accepts 8-bit activations one per handshake, packs them little-endian into
// 32-bit words and streams them to the DMA over AXI4-Stream through a
// 2-entry FIFO. TKEEP marks valid lanes of the final (possibly partial) word,
// TLAST flags it, and send_done reports completion to the control path.
// Only a 32-bit stream (4 bytes per beat) is supported.
module conv_axis_out_packer #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int LEN_WIDTH              = 16
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              start,
    input  logic [LEN_WIDTH-1:0]              out_len,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TVALID,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [3:0]                        M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TUSER,
    output logic                              busy,
    output logic                              send_done
);

    localparam int DW = C_S00_AXIS_TDATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   bytes_left_q, bytes_left_d;
    logic [1:0]             idx_q, idx_d;
    logic [23:0]            pack_q, pack_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;
    logic [DW-1:0]          fifo_data_q [2];
    logic [3:0]             fifo_keep_q [2];
    logic                   fifo_last_q [2];

    logic                   accept;
    logic                   last_byte;
    logic                   push;
    logic                   pop;
    logic [DW-1:0]          word;
    logic [3:0]             word_keep;

    assign accept    = in_valid && in_ready;
    assign last_byte = (bytes_left_q == LEN_WIDTH'(1));
    assign push      = accept && ((idx_q == 2'd3) || last_byte);
    assign pop       = M_AXIS_TVALID && M_AXIS_TREADY;

    // Word being completed this cycle: earlier lanes from the pack register,
    // the incoming byte in the current lane, higher lanes zero.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        word                          = '0;
        word[23:0]                    = pack_q;
        word[{idx_q, 3'b000} +: 8]    = in_data;
        unique case (idx_q)
            2'd0:    word_keep = 4'b0001;
            2'd1:    word_keep = 4'b0011;
            2'd2:    word_keep = 4'b0111;
            default: word_keep = 4'b1111;
        endcase
    end

    // FSM state register.
    // NOTE: sequential blocks use non-blocking assignments only; combinational blocks use blocking ones.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (out_len == '0) ? S_DONE : S_PACK;
            S_PACK:  if (accept && last_byte) state_d = S_DRAIN;
            // Leave once the last beat handshakes so send_done follows it by one cycle.
            S_DRAIN: if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; in_ready looks only at registered FIFO occupancy.
    always_comb begin
        in_ready  = (state_q == S_PACK) && (count_q < 2'd2);
        busy      = (state_q != S_IDLE);
        send_done = (state_q == S_DONE);
    end

    // Byte counter, lane index, pack register and FIFO pointer updates.
    always_comb begin
        bytes_left_d = bytes_left_q;
        idx_d        = idx_q;
        pack_d       = pack_q;
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;
        count_d      = count_q;
        if ((state_q == S_IDLE) && start) begin
            bytes_left_d = out_len;
            idx_d        = 2'd0;
            pack_d       = '0;
        end else if (accept) begin
            bytes_left_d = bytes_left_q - LEN_WIDTH'(1);
            if (push) begin
                idx_d  = 2'd0;
                pack_d = '0;
            end else begin
                idx_d  = idx_q + 2'd1;
                pack_d = word[23:0];
            end
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control and datapath registers; reset discards any partial word and FIFO contents.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bytes_left_q <= '0;
            idx_q        <= 2'd0;
            pack_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            bytes_left_q <= bytes_left_d;
            idx_q        <= idx_d;
            pack_q       <= pack_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage write.
    // NOTE: storage is left unreset on purpose; outputs are masked while the FIFO is empty, so stale entries are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= word;
            fifo_keep_q[wr_ptr_q] <= word_keep;
            fifo_last_q[wr_ptr_q] <= last_byte;
        end
    end

    // Stream outputs come from the FIFO head, held at zero while it is empty.
    always_comb begin
        M_AXIS_TVALID = (count_q != 2'd0);
        M_AXIS_TDATA  = M_AXIS_TVALID ? fifo_data_q[rd_ptr_q] : '0;
        M_AXIS_TKEEP  = M_AXIS_TVALID ? fifo_keep_q[rd_ptr_q] : 4'b0000;
        M_AXIS_TLAST  = M_AXIS_TVALID && fifo_last_q[rd_ptr_q];
        M_AXIS_TUSER  = 1'b0;
    end

endmodule

// File: tb/tb_conv_axis_out_packer.sv
// Directed and randomised bench for conv_axis_out_packer. Expected beats are
// queued when a transfer's bytes are chosen and popped on every stream handshake.
module tb_conv_axis_out_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [15:0] out_len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TVALID;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TUSER;
    logic        busy;
    logic        send_done;

    conv_axis_out_packer #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .LEN_WIDTH(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .start(start),
        .out_len(out_len),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TUSER(M_AXIS_TUSER),
        .busy(busy),
        .send_done(send_done)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  src[$];
    int          src_idx = 0;
    bit          rand_valid = 0;
    bit          rand_ready = 0;
    bit          ready_off = 0;
    bit          start_req = 0;
    logic [15:0] start_len = '0;
    beat_t       exp_q[$];
    bit          held_valid = 0;
    beat_t       held;
    int          beats_seen = 0;
    int          done_seen = 0;
    int          last_beat_cyc = 0;
    int          done_cyc = 0;
    logic [3:0]  last_keep = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, then observe the handshakes
    // that the next rising edge will complete.
    task automatic cycle();
        beat_t cur;
        @(negedge CLK);
        cyc++;
        start     = start_req;
        out_len   = start_len;
        start_req = 0;
        in_valid  = (src_idx < src.size()) && (!rand_valid || ($urandom_range(0, 1) == 1));
        in_data   = in_valid ? src[src_idx] : 8'($urandom);
        M_AXIS_TREADY = !ready_off && (!rand_ready || ($urandom_range(0, 1) == 1));
        #1;
        cur = {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST};
        if (held_valid) begin
            check("tvalid_held", M_AXIS_TVALID, 1);
            check("beat_stable", cur, held);
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (exp_q.size() == 0) check("unexpected_beat", exp_q.size(), 1);
            else check($sformatf("beat%0d", beats_seen), cur, exp_q.pop_front());
            beats_seen++;
            last_beat_cyc = cyc;
            last_keep = M_AXIS_TKEEP;
            held_valid = 0;
        end else if (M_AXIS_TVALID) begin
            held_valid = 1;
            held = cur;
        end else begin
            held_valid = 0;
        end
        if (send_done) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (in_valid && in_ready) src_idx++;
    endtask

    // Choose the bytes of a transfer, queue its expected beats, request start.
    task automatic start_xfer(input int len, input logic [7:0] base, input bit rnd);
        int    nb;
        beat_t b;
        src.delete();
        for (int i = 0; i < len; i++) src.push_back(rnd ? 8'($urandom) : 8'(base + 8'(i)));
        src_idx = 0;
        nb = (len + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            b = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * i + l < len) begin
                    b.data[8 * l +: 8] = src[4 * i + l];
                    b.keep[l] = 1'b1;
                end
            end
            b.last = (i == nb - 1);
            exp_q.push_back(b);
        end
        start_req = 1;
        start_len = 16'(len);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_seen;
        int n = 0;
        while (done_seen == d0 && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_done_seen"}, done_seen - d0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_tvalid"}, M_AXIS_TVALID, 0);
        check({tag, "_tdata"}, M_AXIS_TDATA, 0);
        check({tag, "_tkeep"}, M_AXIS_TKEEP, 0);
        check({tag, "_tlast"}, M_AXIS_TLAST, 0);
        check({tag, "_tuser"}, M_AXIS_TUSER, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_send_done"}, send_done, 0);
    endtask

    initial begin
        int b0;
        int d0;
        int c0;
        RESET = 1'b1;
        start = 1'b0;
        out_len = '0;
        in_data = '0;
        in_valid = 1'b0;
        M_AXIS_TREADY = 1'b0;

        // Reset state.
        repeat (3) cycle();
        check_reset_outputs("rst");
        RESET = 1'b0;
        cycle();

        // Eight bytes, continuous valid, always ready.
        b0 = beats_seen;
        start_xfer(8, 8'h01, 0);
        wait_done(100, "len8");
        check("len8_beats", beats_seen - b0, 2);
        check("len8_done_after_beat", done_cyc - last_beat_cyc, 1);
        cycle();
        check("len8_busy_idle", busy, 0);
        check("len8_done_pulse", send_done, 0);

        // Five bytes: full word then a one-lane word.
        b0 = beats_seen;
        start_xfer(5, 8'hA0, 0);
        wait_done(100, "len5");
        check("len5_beats", beats_seen - b0, 2);
        check("len5_last_keep", last_keep, 4'h1);
        cycle();

        // Twelve bytes against a stalled sink.
        b0 = beats_seen;
        ready_off = 1;
        start_xfer(12, 8'h10, 0);
        repeat (20) cycle();
        check("stall_beats", beats_seen - b0, 0);
        check("stall_bytes_taken", src_idx, 8);
        check("stall_in_ready", in_ready, 0);
        check("stall_tvalid", M_AXIS_TVALID, 1);
        ready_off = 0;
        wait_done(100, "len12");
        check("len12_beats", beats_seen - b0, 3);
        check("len12_queue_empty", exp_q.size(), 0);
        cycle();

        // Zero length, with a second start during DONE that must be ignored.
        b0 = beats_seen;
        d0 = done_seen;
        src.delete();
        src_idx = 0;
        start_req = 1;
        start_len = 16'd0;
        cycle();
        c0 = cyc;
        start_req = 1;
        start_len = 16'd4;
        cycle();
        check("len0_done_cycle", done_cyc - c0, 1);
        repeat (10) cycle();
        check("len0_done_count", done_seen - d0, 1);
        check("len0_no_beats", beats_seen - b0, 0);
        check("len0_busy_idle", busy, 0);

        // Long transfer with random valid and ready.
        b0 = beats_seen;
        rand_valid = 1;
        rand_ready = 1;
        start_xfer(1023, 8'h00, 1);
        wait_done(20000, "len1023");
        rand_valid = 0;
        rand_ready = 0;
        check("len1023_beats", beats_seen - b0, 256);
        check("len1023_last_keep", last_keep, 4'h7);
        check("len1023_queue_empty", exp_q.size(), 0);
        cycle();

        // Reset while a beat is held in the FIFO, then a clean transfer.
        ready_off = 1;
        start_xfer(4, 8'h55, 0);
        repeat (8) cycle();
        check("hold_tvalid", M_AXIS_TVALID, 1);
        d0 = done_seen;
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        src.delete();
        src_idx = 0;
        held_valid = 0;
        ready_off = 0;
        repeat (2) cycle();
        RESET = 1'b0;
        repeat (2) cycle();
        check("midrst_no_done", done_seen - d0, 0);
        b0 = beats_seen;
        start_xfer(4, 8'hC0, 0);
        wait_done(100, "post_rst");
        check("post_rst_beats", beats_seen - b0, 1);
        check("post_rst_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
